// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop.
// Define UART_TX_PARITY_EN to insert the parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Enable,
    input  logic [DATA_BITS-1:0] Tx_Parallel,
    output logic                 Tx_Serial,
    output logic                 Tx_Busy,
    output logic                 Tx_Complete
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        clk_cnt, clk_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 serial_n, busy_n, cmpl_n;
    logic                 bit_done, start_frame;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit, par_bit_n;
`endif

    assign bit_done = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            Tx_Serial   <= 1'b1;
            Tx_Busy     <= 1'b0;
            Tx_Complete <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            clk_cnt     <= clk_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            Tx_Serial   <= serial_n;
            Tx_Busy     <= busy_n;
            Tx_Complete <= cmpl_n;
`ifdef UART_TX_PARITY_EN
            par_bit     <= par_bit_n;
`endif
        end
    end

    // Outputs are computed for the next cycle so every pin comes straight from a flop.
    always_comb begin
        state_n     = state;
        clk_cnt_n   = bit_done ? '0 : clk_cnt + 1'b1;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        serial_n    = Tx_Serial;
        busy_n      = Tx_Busy;
        cmpl_n      = 1'b0;
        start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_bit_n   = par_bit;
`endif
        case (state)
            IDLE: begin
                clk_cnt_n   = '0;
                start_frame = Enable;
            end
            START: begin
                if (bit_done) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    serial_n  = shift[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n   = PARITY;
                        serial_n  = par_bit;
`else
                        state_n   = STOP;
                        serial_n  = 1'b1;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        shift_n   = shift >> 1;
                        serial_n  = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                    serial_n  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (bit_cnt == BW'(STOP_BITS - 1)) begin
                        // Frame end doubles as an acceptance slot so back-to-back frames have no gap.
                        cmpl_n      = 1'b1;
                        state_n     = IDLE;
                        bit_cnt_n   = '0;
                        serial_n    = 1'b1;
                        busy_n      = 1'b0;
                        start_frame = Enable;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (start_frame) begin
            state_n   = START;
            clk_cnt_n = '0;
            bit_cnt_n = '0;
            shift_n   = Tx_Parallel;
            serial_n  = 1'b0;
            busy_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit_n = (^Tx_Parallel) ^ (PARITY_ODD != 0);
`endif
        end
    end

endmodule
